branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter BHT_BITS, default 4, giving log2 of the branch-history-table entry count.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a mispredict (legal range 1..7).
REQ-003 SHALL have port CLK  in  1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1, the asynchronous, active-high reset.
REQ-005 SHALL have port if_pc  in  32, the fetch PC for prediction lookup.
REQ-006 SHALL have port pred_taken  out  1, the prediction for if_pc: combinational, equal to MSB of BHT[if_pc[BHT_BITS+1:2]].
REQ-007 SHALL have port br_valid  in  1, asserted when a conditional branch is presented for resolution.
REQ-008 SHALL have port br_ready  out  1; resolution is accepted when br_valid and br_ready are both high.
REQ-009 SHALL have port br_funct3  in  3, the branch funct3 field.
REQ-010 SHALL have port br_cond  in  3, the comparator result {eq, signed A>B, unsigned A>B}.
REQ-011 SHALL have ports br_pc  in  32 and br_target  in  32, the branch PC and its computed taken target.
REQ-012 SHALL have port br_pred  in  1, the prediction carried down the pipe with the branch.
REQ-013 SHALL have ports flush  out  1 and redirect_pc  out  32, the pipeline flush request and the correct next PC.
REQ-014 SHALL have ports illegal  out  1, a one-cycle pulse for an accepted funct3 of 010 or 011.
REQ-015 SHALL have ports br_count  out  16 and miss_count  out  16, the accepted-branch and mispredict counters.

Function
REQ-016 The outcome SHALL be decoded combinationally as follows: 000 -> eq; 001 -> !eq; 100 -> !eq&!sgt; 101 -> eq|sgt; 110 -> !eq&!ugt; 111 -> eq|ugt; 010/011 -> not taken plus illegal.
REQ-017 A mispredict SHALL be an accepted, legal branch with taken != br_pred.
REQ-018 The FSM SHALL have states IDLE and FLUSH; br_ready SHALL be 1 in IDLE and 0 in FLUSH.
REQ-019 IDLE->FLUSH SHALL occur on an accepted mispredict; the next cycle sets flush=1, redirect_pc=taken?br_target:br_pc+4 (mod 2^32), and the flush counter = FLUSH_CYCLES-1.
REQ-020 In FLUSH, flush SHALL stay 1 and redirect_pc SHALL stay stable while the counter decrements each cycle; at counter 0 the FSM SHALL return to IDLE with flush=0 one cycle later, so flush is high exactly FLUSH_CYCLES cycles.
REQ-021 A correctly predicted branch SHALL leave flush at 0 and the FSM in IDLE.
REQ-022 br_valid during FLUSH SHALL be ignored, with no counter, BHT or state change.
REQ-023 On every accepted legal branch, BHT[br_pc[BHT_BITS+1:2]] SHALL update as a 2-bit saturating counter: +1 if taken (saturate at 11), -1 if not (saturate at 00); illegal branches SHALL NOT update the BHT.
REQ-024 A lookup and an update to the same index in one cycle SHALL return the pre-update value.
REQ-025 br_count SHALL increment on every accepted branch, including illegal ones; miss_count SHALL increment on every mispredict; both SHALL wrap from 0xFFFF to 0x0000.
REQ-026 All outputs except pred_taken and br_ready SHALL be registered.

Reset
REQ-027 RST high SHALL asynchronously force state=IDLE, flush=0, redirect_pc=0, illegal=0, br_count=0, miss_count=0, and every BHT entry to 01 (weakly not-taken).
REQ-028 RST asserted during FLUSH SHALL abort the flush immediately; the first cycle after deassertion SHALL be IDLE with br_ready=1.

Structure
REQ-029 funct3 encodings, FSM state encodings and the BHT reset value 2'b01 SHALL live in shared package riscv_pkg.
REQ-030 The saturating counter update SHALL be the single sub-module sat_counter2, a combinational next-value function on 2 bits; the BHT array stays in branch_resolver.

Verification
REQ-031 After reset, if_pc=0x40 -> pred_taken=0; br_count=0; miss_count=0; br_ready=1.
REQ-032 BEQ, br_cond=100, br_pred=0, br_pc=0x100, br_target=0x80 -> flush high 2 cycles, redirect_pc=0x80, miss_count=1, br_ready low 2 cycles.
REQ-033 BLTU, br_cond=000, br_pred=1, br_pc=0x200 -> no flush; BHT[0] goes 01->10; next lookup at if_pc=0x200 gives pred_taken=1.
REQ-034 BGE not taken, mispredicted, br_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
REQ-035 funct3=010 accepted -> illegal pulse for 1 cycle, br_count+1, no BHT change, no flush.
REQ-036 Three taken updates to one index, then five not-taken updates -> counter sequence 10,11,11,10,01,00,00,00; RST pulsed mid-FLUSH -> flush=0 immediately, br_ready=1 after deassertion.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the branch resolution logic:
//   - conditional-branch funct3 encodings (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   - the two-state resolver FSM encoding
//   - the reset value of every branch-history-table entry (weakly not-taken)
//   - the comparator-flag bit positions inside br_cond
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Conditional branch funct3 encodings; 010 and 011 are reserved.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Positions of the comparator flags inside br_cond = {eq, sgt, ugt}.
  localparam int COND_EQ  = 2;
  localparam int COND_SGT = 1;
  localparam int COND_UGT = 0;

  // Every BHT entry comes out of reset as weakly not-taken.
  localparam logic [1:0] BHT_RESET = 2'b01;

  // Resolver FSM: IDLE accepts branches, FLUSH holds the pipeline flush.
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_resolver_if
// Bundle of every signal between the pipeline and the branch resolver.
//   Fetch side   : if_pc (in), pred_taken (out, combinational)
//   Resolve side : br_valid/br_ready handshake, br_funct3, br_cond,
//                  br_pc, br_target, br_pred
//   Results      : flush, redirect_pc, illegal, br_count, miss_count
// The master modport is the pipeline; the slave modport is the resolver.
// ---------------------------------------------------------------------------
interface branch_resolver_if;

  logic [31:0] if_pc;
  logic        pred_taken;

  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic [2:0]  br_cond;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        br_pred;

  logic        flush;
  logic [31:0] redirect_pc;
  logic        illegal;
  logic [15:0] br_count;
  logic [15:0] miss_count;

  // Pipeline side: presents PCs and branches, consumes predictions/results.
  modport master (
    output if_pc, br_valid, br_funct3, br_cond, br_pc, br_target, br_pred,
    input  pred_taken, br_ready, flush, redirect_pc, illegal,
           br_count, miss_count
  );

  // Resolver side.
  modport slave (
    input  if_pc, br_valid, br_funct3, br_cond, br_pc, br_target, br_pred,
    output pred_taken, br_ready, flush, redirect_pc, illegal,
           br_count, miss_count
  );

endinterface

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Next-value function of a 2-bit saturating counter (purely combinational).
//   cnt_i : current counter value
//   inc_i : 1 = count up (saturate at 11), 0 = count down (saturate at 00)
//   cnt_o : next counter value
// ---------------------------------------------------------------------------
module sat_counter2 (
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  // Step one towards the requested direction, sticking at either end.
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != 2'b11) begin
        cnt_o = cnt_i + 2'd1;
      end
    end else begin
      if (cnt_i != 2'b00) begin
        cnt_o = cnt_i - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Resolves conditional branches, trains a 2-bit branch history table and
// requests a pipeline flush on a mispredict.
//   CLK : clock, all state changes on the rising edge
//   RST : asynchronous active-high reset
//   bus : branch_resolver_if.slave
//         if_pc      -> pred_taken   (combinational BHT lookup)
//         br_valid / br_ready        (br_ready combinational, high in IDLE)
//         br_funct3, br_cond, br_pc, br_target, br_pred (branch to resolve)
//         flush, redirect_pc, illegal, br_count, miss_count (registered)
// Parameters:
//   BHT_BITS     : log2 of the number of BHT entries
//   FLUSH_CYCLES : number of cycles flush stays high after a mispredict (1..7)
// ---------------------------------------------------------------------------
module branch_resolver
  import riscv_pkg::*;
#(
  parameter int BHT_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              CLK,
  input logic              RST,
  branch_resolver_if.slave bus
);

  localparam int         BHT_ENTRIES = 1 << BHT_BITS;
  localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);

  // Branch history table: one 2-bit saturating counter per entry.
  logic [1:0]          bht_q [BHT_ENTRIES];

  logic [BHT_BITS-1:0] lookupIdx;
  logic [BHT_BITS-1:0] updateIdx;
  logic [1:0]          bhtCur;
  logic [1:0]          bhtNext;
  logic                bhtWe;

  br_state_e           state_q, state_d;
  logic [2:0]          flushCnt_q, flushCnt_d;
  logic                flush_q, flush_d;
  logic [31:0]         redirectPc_q, redirectPc_d;
  logic                illegal_q, illegal_d;
  logic [15:0]         brCount_q, brCount_d;
  logic [15:0]         missCount_q, missCount_d;

  logic                condEq, condSgt, condUgt;
  logic                taken;
  logic                illegalF3;
  logic                accept;
  logic                unusedIfPcBits;

  // Word-aligned PCs: the low two bits never select a BHT entry.
  assign lookupIdx = bus.if_pc[BHT_BITS+1:2];
  assign updateIdx = bus.br_pc[BHT_BITS+1:2];

  // The remaining fetch-PC bits play no part in the lookup.
  assign unusedIfPcBits = ^{bus.if_pc[31:BHT_BITS+2], bus.if_pc[1:0]};

  // Prediction reads the registered table, so a same-cycle update to the
  // same entry is not yet visible and the pre-update value is returned.
  assign bus.pred_taken = bht_q[lookupIdx][1];

  // Branches are only taken while no flush is in progress.
  assign bus.br_ready = (state_q == IDLE);
  assign accept       = bus.br_valid && bus.br_ready;

  assign condEq  = bus.br_cond[COND_EQ];
  assign condSgt = bus.br_cond[COND_SGT];
  assign condUgt = bus.br_cond[COND_UGT];

  // Outcome decode from the comparator flags; reserved funct3 values
  // resolve as not taken and are flagged illegal.
  always_comb begin
    taken     = 1'b0;
    illegalF3 = 1'b0;
    case (bus.br_funct3)
      F3_BEQ:  taken = condEq;
      F3_BNE:  taken = !condEq;
      F3_BLT:  taken = !condEq && !condSgt;
      F3_BGE:  taken = condEq || condSgt;
      F3_BLTU: taken = !condEq && !condUgt;
      F3_BGEU: taken = condEq || condUgt;
      default: illegalF3 = 1'b1;
    endcase
  end

  // Saturating update of the entry addressed by the resolving branch.
  assign bhtCur = bht_q[updateIdx];

  sat_counter2 u_sat (
    .cnt_i (bhtCur),
    .inc_i (taken),
    .cnt_o (bhtNext)
  );

  // Next-state logic: IDLE accepts branches and counts them; a legal
  // mispredict loads the redirect PC and enters FLUSH, where the flush
  // counter runs down to zero before returning to IDLE. Branches offered
  // during FLUSH are never accepted, so nothing below reacts to them.
  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    flush_d      = flush_q;
    redirectPc_d = redirectPc_q;
    illegal_d    = 1'b0;
    brCount_d    = brCount_q;
    missCount_d  = missCount_q;
    bhtWe        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          brCount_d = brCount_q + 16'd1;
          if (illegalF3) begin
            illegal_d = 1'b1;
          end else begin
            bhtWe = 1'b1;
            if (taken != bus.br_pred) begin
              missCount_d  = missCount_q + 16'd1;
              state_d      = FLUSH;
              flush_d      = 1'b1;
              flushCnt_d   = FLUSH_INIT;
              redirectPc_d = taken ? bus.br_target : (bus.br_pc + 32'd4);
            end
          end
        end
      end

      FLUSH: begin
        if (flushCnt_q == 3'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          flushCnt_d = flushCnt_q - 3'd1;
        end
      end
    endcase
  end

  // State and result registers; reset aborts any flush in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      flushCnt_q   <= 3'd0;
      flush_q      <= 1'b0;
      redirectPc_q <= 32'd0;
      illegal_q    <= 1'b0;
      brCount_q    <= 16'd0;
      missCount_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      flush_q      <= flush_d;
      redirectPc_q <= redirectPc_d;
      illegal_q    <= illegal_d;
      brCount_q    <= brCount_d;
      missCount_q  <= missCount_d;
    end
  end

  // BHT storage: all entries return to weakly not-taken on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= BHT_RESET;
      end
    end else if (bhtWe) begin
      bht_q[updateIdx] <= bhtNext;
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirectPc_q;
  assign bus.illegal     = illegal_q;
  assign bus.br_count    = brCount_q;
  assign bus.miss_count  = missCount_q;

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
// Directed bench for branch_resolver (BHT_BITS=4, FLUSH_CYCLES=2): a table
// of single-branch vectors with hand-computed results, followed by
// hand-written sequences for BHT training, saturation, illegal funct3,
// branches offered during FLUSH and reset in the middle of a flush.
// ---------------------------------------------------------------------------
module tb_branch_resolver;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;
  int expBr   = 0;
  int expMiss = 0;

  branch_resolver_if bus ();

  branch_resolver #(
    .BHT_BITS     (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  funct3;
    logic [2:0]  cond;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
    logic        expFlush;
    logic        expIllegal;
    logic [31:0] expRedirect;
  } vec_t;

  vec_t vecs [11];

  // One comparison; a mismatch prints a FAIL line and bumps the count.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a branch on the falling edge with br_valid high.
  task automatic driveBranch(input logic [2:0] f3, input logic [2:0] cond,
                             input logic pred, input logic [31:0] pc,
                             input logic [31:0] target);
    @(negedge clk);
    bus.br_funct3 = f3;
    bus.br_cond   = cond;
    bus.br_pred   = pred;
    bus.br_pc     = pc;
    bus.br_target = target;
    bus.br_valid  = 1'b1;
  endtask

  // Drive a branch, clock it in and leave the bench 1 ns after the edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [2:0] cond,
                               input logic pred, input logic [31:0] pc,
                               input logic [31:0] target);
    driveBranch(f3, cond, pred, pc, target);
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    bus.br_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    expBr   = 0;
    expMiss = 0;
  endtask

  initial begin
    logic expMsb [8];

    rst           = 1'b1;
    bus.if_pc     = 32'h0;
    bus.br_valid  = 1'b0;
    bus.br_funct3 = 3'b000;
    bus.br_cond   = 3'b000;
    bus.br_pc     = 32'h0;
    bus.br_target = 32'h0;
    bus.br_pred   = 1'b0;

    // funct3, cond{eq,sgt,ugt}, pred, pc, target, flush, illegal, redirect
    vecs[0]  = '{F3_BEQ,  3'b100, 1'b0, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0080};
    vecs[1]  = '{F3_BNE,  3'b100, 1'b0, 32'h0000_0104, 32'h0000_0300, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{F3_BNE,  3'b000, 1'b0, 32'h0000_0108, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0400};
    vecs[3]  = '{F3_BLT,  3'b001, 1'b1, 32'h0000_0010, 32'h0000_0800, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{F3_BLT,  3'b010, 1'b1, 32'h0000_010C, 32'h0000_0900, 1'b1, 1'b0, 32'h0000_0110};
    vecs[5]  = '{F3_BGE,  3'b000, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0000};
    vecs[6]  = '{F3_BGEU, 3'b001, 1'b0, 32'h0000_0020, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1000};
    vecs[7]  = '{F3_BLTU, 3'b001, 1'b0, 32'h0000_0024, 32'h0000_2000, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{3'b010,  3'b100, 1'b1, 32'h0000_0028, 32'h0000_3000, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{3'b011,  3'b000, 1'b1, 32'h0000_002C, 32'h0000_4000, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{F3_BGEU, 3'b100, 1'b1, 32'h0000_0030, 32'h0000_5000, 1'b0, 1'b0, 32'h0};

    // Reset state.
    doReset();
    bus.if_pc = 32'h40;
    #1;
    checkOutput("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
    checkOutput("rst_br_count",   32'(bus.br_count),   32'h0);
    checkOutput("rst_miss_count", 32'(bus.miss_count), 32'h0);
    checkOutput("rst_br_ready",   32'(bus.br_ready),   32'h1);
    checkOutput("rst_flush",      32'(bus.flush),      32'h0);
    checkOutput("rst_redirect",   bus.redirect_pc,     32'h0);
    checkOutput("rst_illegal",    32'(bus.illegal),    32'h0);

    // Table-driven single branches.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].funct3, vecs[i].cond, vecs[i].pred,
                    vecs[i].pc, vecs[i].target);
      expBr++;
      if (vecs[i].expFlush) expMiss++;
      checkOutput($sformatf("v%0d_flush", i),   32'(bus.flush),      32'(vecs[i].expFlush));
      checkOutput($sformatf("v%0d_illegal", i), 32'(bus.illegal),    32'(vecs[i].expIllegal));
      checkOutput($sformatf("v%0d_ready", i),   32'(bus.br_ready),   32'(!vecs[i].expFlush));
      checkOutput($sformatf("v%0d_brcnt", i),   32'(bus.br_count),   32'(expBr));
      checkOutput($sformatf("v%0d_misscnt", i), 32'(bus.miss_count), 32'(expMiss));
      if (vecs[i].expFlush) begin
        checkOutput($sformatf("v%0d_redirect", i), bus.redirect_pc, vecs[i].expRedirect);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_flush_c2", i),  32'(bus.flush),    32'h1);
        checkOutput($sformatf("v%0d_ready_c2", i),  32'(bus.br_ready), 32'h0);
        checkOutput($sformatf("v%0d_redir_c2", i),  bus.redirect_pc,   vecs[i].expRedirect);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_flush_end", i), 32'(bus.flush),    32'h0);
        checkOutput($sformatf("v%0d_ready_end", i), 32'(bus.br_ready), 32'h1);
      end else begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_illegal_c2", i), 32'(bus.illegal), 32'h0);
      end
    end

    // BHT training at index 0, with same-cycle lookup returning old value.
    doReset();
    bus.if_pc = 32'h200;
    driveBranch(F3_BLTU, 3'b000, 1'b1, 32'h200, 32'h600);
    #1;
    checkOutput("bht_pre_update", 32'(bus.pred_taken), 32'h0);
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    checkOutput("bht_no_flush",    32'(bus.flush),      32'h0);
    checkOutput("bht_post_update", 32'(bus.pred_taken), 32'h1);
    bus.if_pc = 32'h204;
    #1;
    checkOutput("bht_other_index", 32'(bus.pred_taken), 32'h0);

    // Illegal funct3 must not touch the BHT (index 1 trained to 10 first).
    doReset();
    bus.if_pc = 32'h44;
    applyStimulus(F3_BEQ, 3'b100, 1'b1, 32'h44, 32'h900);
    checkOutput("ill_pretrain", 32'(bus.pred_taken), 32'h1);
    applyStimulus(3'b010, 3'b000, 1'b1, 32'h44, 32'h0);
    checkOutput("ill_pulse",    32'(bus.illegal),    32'h1);
    checkOutput("ill_no_flush", 32'(bus.flush),      32'h0);
    checkOutput("ill_brcnt",    32'(bus.br_count),   32'h2);
    checkOutput("ill_misscnt",  32'(bus.miss_count), 32'h0);
    checkOutput("ill_bht_kept", 32'(bus.pred_taken), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("ill_pulse_end", 32'(bus.illegal), 32'h0);

    // Saturation: 3 taken then 5 not-taken at index 3 -> 10,11,11,10,01,00,00,00.
    doReset();
    bus.if_pc = 32'hC;
    expMsb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      if (k < 3) applyStimulus(F3_BEQ, 3'b100, 1'b1, 32'hC, 32'h500);
      else       applyStimulus(F3_BEQ, 3'b000, 1'b0, 32'hC, 32'h500);
      checkOutput($sformatf("sat_step%0d", k), 32'(bus.pred_taken), 32'(expMsb[k]));
      checkOutput($sformatf("sat_flush%0d", k), 32'(bus.flush), 32'h0);
    end
    checkOutput("sat_brcnt", 32'(bus.br_count), 32'h8);

    // A branch offered during FLUSH is ignored.
    doReset();
    applyStimulus(F3_BEQ, 3'b100, 1'b0, 32'h100, 32'h80);
    checkOutput("fl_flush", 32'(bus.flush), 32'h1);
    driveBranch(F3_BNE, 3'b000, 1'b0, 32'h300, 32'h700);
    checkOutput("fl_ready_low", 32'(bus.br_ready), 32'h0);
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    checkOutput("fl_brcnt",    32'(bus.br_count),   32'h1);
    checkOutput("fl_misscnt",  32'(bus.miss_count), 32'h1);
    checkOutput("fl_redirect", bus.redirect_pc,     32'h80);
    @(posedge clk);
    #1;
    checkOutput("fl_flush_end", 32'(bus.flush),    32'h0);
    checkOutput("fl_ready_end", 32'(bus.br_ready), 32'h1);
    checkOutput("fl_brcnt_end", 32'(bus.br_count), 32'h1);

    // Reset in the middle of a flush aborts it immediately.
    applyStimulus(F3_BEQ, 3'b100, 1'b0, 32'h100, 32'h80);
    checkOutput("rf_flush_on", 32'(bus.flush), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rf_flush_off", 32'(bus.flush),      32'h0);
    checkOutput("rf_ready",     32'(bus.br_ready),   32'h1);
    checkOutput("rf_brcnt",     32'(bus.br_count),   32'h0);
    checkOutput("rf_redirect",  bus.redirect_pc,     32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rf_ready_after", 32'(bus.br_ready), 32'h1);
    checkOutput("rf_flush_after", 32'(bus.flush),    32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
